// File: rtl/seg_pkg.sv
// Shared constants for the 4-digit multiplexed hex display: segment table,
// digit count and the scan state encoding.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic {
    BLANK = 1'b0,
    SCAN  = 1'b1
  } state_e;

  // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-high 7-segment pattern.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_HEX[nibble_i];

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed 4-digit hex display. The shown value is latched once per
// frame so a digit never tears; dp on digit 0 flags a changed value.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 50000,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter bit          BLANK_LZ   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] test_value,
  input  logic        en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        dbg_state
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  state_e                  state_q, state_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [1:0]              idx_q, idx_d;
  logic [15:0]             disp_q, disp_d;
  logic                    chg_q, chg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    tick;
  logic [3:0]              nib;
  logic [6:0]              hex_seg;
  logic                    blank_digit;

  assign nib = disp_q[{idx_q, 2'b00} +: 4];

  hex_to_seg u_hex (
    .nibble_i (nib),
    .seg_o    (hex_seg)
  );

  // Digit k>=1 is a leading zero when it and every higher nibble are zero.
  assign blank_digit = BLANK_LZ && (idx_q != 2'd0) &&
                       ((disp_q >> {idx_q, 2'b00}) == 16'h0000);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BLANK;
      presc_q <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
      chg_q   <= 1'b0;
      an_q    <= '0;
      seg_q   <= '0;
      dp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      chg_q   <= chg_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    idx_d   = idx_q;
    disp_d  = disp_q;
    chg_d   = chg_q;
    tick    = 1'b0;
    case (state_q)
      BLANK: begin
        presc_d = '0;
        idx_d   = '0;
        if (en) begin
          state_d = SCAN;
          disp_d  = test_value;
          chg_d   = (test_value != disp_q);
        end
      end
      SCAN: begin
        // Dropping en beats a coincident tick: the frame is abandoned unlatched.
        if (!en) begin
          state_d = BLANK;
          presc_d = '0;
          idx_d   = '0;
        end else begin
          tick    = (presc_q == PRESC_MAX);
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            idx_d = idx_q + 1'b1;
            if (idx_q == 2'd3) begin
              disp_d = test_value;
              chg_d  = (test_value != disp_q);
            end
          end
        end
      end
      default: state_d = BLANK;
    endcase
  end

  // Gating on en blanks the pins on the same edge that leaves SCAN, as reset does.
  always_comb begin
    an_d  = '0;
    seg_d = '0;
    dp_d  = 1'b0;
    if (state_q == SCAN && en) begin
      if (!blank_digit) begin
        an_d[idx_q] = 1'b1;
        seg_d       = hex_seg;
      end
      dp_d = (idx_q == 2'd0) && chg_q;
    end
  end

  assign an        = ACTIVE_LOW ? ~an_q  : an_q;
  assign seg       = ACTIVE_LOW ? ~seg_q : seg_q;
  assign dp        = ACTIVE_LOW ? ~dp_q  : dp_q;
  assign dbg_state = (state_q == SCAN);

endmodule
